// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter handing bytes from four requesters to one UART transmitter; define UART_TX_ARB_LOCK_EN to hold the grant on one requester until its last byte
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BUSY_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active,
  output logic                 err_timeout
);
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d, grant_q, grant_d, mask, sel_oh;
  logic [7:0] tx_data_q, tx_data_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] last_grant_q, last_grant_d, sel, idx;
  logic tx_start_q, tx_start_d, err_q, err_d, found, accept;
`ifdef UART_TX_ARB_LOCK_EN
  logic lock_q, lock_d;
  // while locked only the owner of the open packet may win
  always_comb begin
    mask = '1;
    if (lock_q) begin
      mask = '0;
      mask[last_grant_q] = 1'b1;
    end
  end
  // a non-final byte locks; the final byte or a timeout releases
  always_comb lock_d = accept ? !req_last[sel] : (err_d ? 1'b0 : lock_q);
  // lock register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else lock_q <= lock_d;
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign mask = '1;
`endif
  // round-robin search starting one past the previous winner
  always_comb begin
    sel = '0;
    sel_oh = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_q + 2'(k);
      if (!found && req_valid[idx] && mask[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
    sel_oh[sel] = found;
  end
  assign accept = (state_q == IDLE) && found && !tx_busy;
  // next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    req_ready_d = '0;
    tx_start_d = 1'b0;
    tx_data_d = tx_data_q;
    grant_d = grant_q;
    err_d = 1'b0;
    cnt_d = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        req_ready_d = sel_oh;
        tx_start_d = 1'b1;
        tx_data_d = req_data[8*sel +: 8];
        grant_d = sel_oh;
        last_grant_d = sel;
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d = '0;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      else begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == 4'(BUSY_WAIT_MAX)) begin
          err_d = 1'b1;
          state_d = IDLE;
          grant_d = '0;
        end
      end
      WAIT_DONE: if (!tx_busy) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset aborts any transfer at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_ready_q <= '0;
      tx_start_q <= 1'b0;
      tx_data_q <= '0;
      grant_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      last_grant_q <= 2'd3;
    end else begin
      state_q <= state_d;
      req_ready_q <= req_ready_d;
      tx_start_q <= tx_start_d;
      tx_data_q <= tx_data_d;
      grant_q <= grant_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign req_ready = req_ready_q;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign grant = grant_q;
  assign err_timeout = err_q;
  assign active = state_q != IDLE;
endmodule
